hilo_divider: RTL and testbench
===============================

Name: hilo_divider

Overview:
- Multi-cycle restoring divider. It is the inverse of the ALU's single-cycle multiply, which writes {hi,lo}.
- Produces quotient on lo and remainder on hi, matching MIPS div/divu HI/LO semantics.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy and captures hi/lo on done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- is_signed  input  1  1 = div (signed), 0 = divu; see Optional Feature.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when hi/lo are valid.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.
- div_by_zero  output  1  flag for the last completed operation: divisor was zero.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; iteration counter=0.
- rst wins over every other input in the same cycle.
- rst mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: if start, latch a, b and is_signed, then go to RUN.
  - RUN: one quotient bit per cycle, MSB first, for WIDTH cycles; then go to FIX.
  - FIX: apply signs, write hi/lo, pulse done, then go to IDLE.
- Timing:
  - start sampled at edge N.
  - busy=1 from after edge N through edge N+WIDTH+1.
  - hi/lo/div_by_zero update at edge N+WIDTH+1; done=1 for exactly that following cycle; busy=0 in that cycle.
  - Total latency is WIDTH+1 cycles, constant for all operands including divide-by-zero.
- start while busy: ignored, no queuing. Operands are latched, so a/b may change freely after acceptance.
- start in the done cycle (state IDLE): accepted. Back-to-back throughput is one op per WIDTH+1 cycles.
- hi/lo hold their values until the next completion; they do not change at start acceptance.
- Datapath:
  - Partial remainder register is WIDTH+1 bits. Each cycle, shift the remainder left, bringing in the next dividend bit, then trial-subtract the divisor magnitude.
  - Non-negative trial result: keep it, quotient bit = 1. Negative: restore, quotient bit = 0.
- Signed handling:
  - Operate on magnitudes |a| and |b|.
  - Quotient negated if a[WIDTH-1]^b[WIDTH-1].
  - Remainder takes the sign of the dividend.
  - Most-negative / -1: lo=0x80000000, hi=0 (the wrapped result, no trap).
- Divide by zero (b==0):
  - lo = all ones, hi = a unchanged (both signed and unsigned), div_by_zero=1.
  - Otherwise div_by_zero=0 at completion.
- No overflow output; the EPC path does not trap on division.

Optional Feature:
- Macro: HILO_DIVIDER_SIGNED_EN.
- Defined: is_signed is honored as described above.
- Undefined:
  - is_signed is ignored and every operation is unsigned.
  - Sign-fix logic is not synthesized; FIX still takes one cycle, so latency is unchanged.
  - The port remains present.

Test Plan:
- Unsigned basic: a=100, b=7, is_signed=0, start at edge 0 -> busy edges 1..33, done at edge 33 with lo=14, hi=2, div_by_zero=0.
- Signed mixed signs (macro defined): a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=-2 -> lo=-3, hi=1.
- Edge operands:
  - a=0x80000000, b=0xFFFFFFFF, signed -> lo=0x80000000, hi=0.
  - Same operands unsigned -> lo=0, hi=0x80000000.
- Divide by zero: a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1, done after the same WIDTH+1 latency.
- Handshake:
  - start pulsed at cycle 5 of a running op with different operands -> ignored; the first result is unaffected and only one done is seen.
  - start in the done cycle -> accepted; second done exactly WIDTH+1 cycles later.
- Reset mid-op: rst at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, no done; a fresh start then completes normally (a=9, b=3 -> lo=3, hi=0).

Source files
------------

// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider producing MIPS-style HI (remainder) / LO (quotient).
// Define HILO_DIVIDER_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_bmag;
    logic [WIDTH-1:0] r_a;
    logic             r_bz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_trial_neg;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // The remainder stays below the divisor magnitude, so WIDTH+2 bits hold the
    // shifted value with a spare sign bit for the trial subtraction.
    assign w_shift     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift - {2'b00, r_bmag};
    assign w_trial_neg = w_trial[WIDTH+1];

`ifdef HILO_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg  = is_signed & a[WIDTH-1];
    assign w_b_neg  = is_signed & b[WIDTH-1];
    assign w_amag   = w_a_neg ? (~a + 1'b1) : a;
    assign w_bmag   = w_b_neg ? (~b + 1'b1) : b;
    assign w_lo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_hi_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = is_signed;
    assign w_amag          = a;
    assign w_bmag          = b;
    assign w_lo_fix        = r_quo;
    assign w_hi_fix        = r_rem[WIDTH-1:0];
`endif

    // r_quo starts as the dividend magnitude; its bits shift out into the
    // remainder while quotient bits shift in from the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_bmag        <= '0;
            r_a           <= '0;
            r_bz          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_amag;
                        r_bmag  <= w_bmag;
                        r_a     <= a;
                        r_bz    <= (b == '0);
                    end
                end
                S_RUN: begin
                    r_rem   <= w_trial_neg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_trial_neg};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_div_by_zero <= r_bz;
                    if (r_bz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_hi_fix;
                        r_lo <= w_lo_fix;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed bench for hilo_divider: latency, HI/LO results, divide-by-zero, handshake and reset abort.
module tb_hilo_divider;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

`ifdef HILO_DIVIDER_SIGNED_EN
    localparam logic [31:0] S1_LO = 32'hFFFFFFFD, S1_HI = 32'hFFFFFFFF;
    localparam logic [31:0] S2_LO = 32'hFFFFFFFD, S2_HI = 32'h00000001;
    localparam logic [31:0] S3_LO = 32'h80000000, S3_HI = 32'h00000000;
    localparam logic [31:0] S4_LO = 32'd14,       S4_HI = 32'hFFFFFFFE;
`else
    localparam logic [31:0] S1_LO = 32'h7FFFFFFC, S1_HI = 32'h00000001;
    localparam logic [31:0] S2_LO = 32'h00000000, S2_HI = 32'h00000007;
    localparam logic [31:0] S3_LO = 32'h00000000, S3_HI = 32'h80000000;
    localparam logic [31:0] S4_LO = 32'h00000000, S4_HI = 32'hFFFFFF9C;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    hilo_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one op and waits (bounded) for done; leaves time in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sg, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_dbz);
        int lat;
        int busy_bad;
        bit seen;
        a = av; b = bv; is_signed = sg; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
        lat = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && lat < LAT + 8) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            lat++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busy_run"}, busy_bad, 0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    endtask

    initial begin
        int cyc;
        int first;
        int n_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        tick();

        run_op("u_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        tick();
        run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, S1_LO, S1_HI, 1'b0);
        run_op("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, S2_LO, S2_HI, 1'b0);
        run_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, S3_LO, S3_HI, 1'b0);
        run_op("u_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0);
        run_op("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, S4_LO, S4_HI, 1'b0);
        run_op("u_dbz", 32'h1234, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1);
        run_op("s_dbz", 32'hFFFFFFF0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1);
        tick();

        // A second start mid-run must be dropped; results must hold meanwhile.
        a = 32'd1000; b = 32'd10; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("hold_lo", lo, 32'hFFFFFFFF);
        check("hold_hi", hi, 32'hFFFFFFF0);
        check("hold_dbz", 32'(div_by_zero), 1);
        a = 32'd50; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 6; first = 0; n_done = 0;
        repeat (2 * LAT) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                n_done++;
                if (first == 0) first = cyc;
            end
        end
        check("ign_first_done", first, LAT);
        check("ign_n_done", n_done, 1);
        check("ign_lo", lo, 32'd100);
        check("ign_hi", hi, 32'd0);
        check("ign_dbz", 32'(div_by_zero), 0);

        // Start issued in the done cycle of the previous op.
        run_op("b2b_a", 32'd55, 32'd6, 1'b0, 32'd9, 32'd1, 1'b0);
        run_op("b2b_b", 32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0);
        tick();

        // Reset during RUN aborts without a done pulse.
        a = 32'd123456; b = 32'd7; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        n_done = 0;
        repeat (LAT + 5) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
